// File: rtl/offchip_line_bridge.sv
// offchip_line_bridge
//   Splits cache-line transfers from the memory controller's off-chip channel
//   into single-word beats on the external bus. A read fills offchip_mem_data
//   from LINE_BYTES/4 word reads. A write-back sends the latched line as
//   LINE_BYTES/4 word writes.
// Ports
//   clk, rst (async, active low)
//   upstream  : offchip_mem_addr, offchip_mem_read_en, offchip_mem_write_en,
//               offchip_mem_wdata -> offchip_mem_data, offchip_mem_ready,
//               offchip_err, bridge_busy
//   downstream: bus_req, bus_we, bus_addr, bus_wdata <- bus_rdata, bus_ack
module offchip_line_bridge #(
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             offchip_mem_addr,
  input  logic                    offchip_mem_read_en,
  input  logic                    offchip_mem_write_en,
  input  logic [LINE_BYTES*8-1:0] offchip_mem_wdata,
  output logic [LINE_BYTES*8-1:0] offchip_mem_data,
  output logic                    offchip_mem_ready,
  output logic                    offchip_err,
  output logic                    bridge_busy,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [31:0]             bus_addr,
  output logic [31:0]             bus_wdata,
  input  logic [31:0]             bus_rdata,
  input  logic                    bus_ack
);

  localparam int unsigned BEATS = LINE_BYTES / 4;
  localparam int unsigned BW    = $clog2(BEATS) + 1;
  localparam int unsigned TW    = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [31:0] ALIGN_MASK = ~(32'(LINE_BYTES) - 32'd1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                  state, state_nxt;
  logic [BW-1:0]           beat, beat_nxt;
  logic [TW-1:0]           timer;
  logic [LINE_BYTES*8-1:0] wline;
  logic                    rd_served, wr_served;
  logic                    accept_wr, accept_rd;
  logic                    active, expired, advance, last;

  // Write wins when both enables are pending.
  assign accept_wr = offchip_mem_write_en && !wr_served;
  assign accept_rd = !accept_wr && offchip_mem_read_en && !rd_served;

  // Acks are only honoured while a beat is outstanding (bus_req is high
  // exactly when the state is RD or WR).
  assign active   = (state == RD) || (state == WR);
  assign expired  = active && !bus_ack && (timer == TW'(TIMEOUT - 1));
  assign advance  = active && (bus_ack || expired);
  assign last     = (beat == BW'(BEATS - 1));
  assign beat_nxt = beat + BW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept_wr)      state_nxt = WR;
        else if (accept_rd) state_nxt = RD;
      end
      RD, WR: begin
        if (advance && last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      offchip_mem_data  <= '0;
      offchip_mem_ready <= 1'b0;
      offchip_err       <= 1'b0;
      bridge_busy       <= 1'b0;
      bus_req           <= 1'b0;
      bus_we            <= 1'b0;
      bus_addr          <= '0;
      bus_wdata         <= '0;
      wline             <= '0;
      beat              <= '0;
      timer             <= '0;
    end else begin
      offchip_mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_wr || accept_rd) begin
            bus_req     <= 1'b1;
            bus_we      <= accept_wr;
            bus_addr    <= offchip_mem_addr & ALIGN_MASK;
            bus_wdata   <= accept_wr ? offchip_mem_wdata[31:0] : '0;
            beat        <= '0;
            timer       <= '0;
            offchip_err <= 1'b0;
            bridge_busy <= 1'b1;
            if (accept_wr) wline <= offchip_mem_wdata;
          end
        end
        RD, WR: begin
          if (advance) begin
            // An abandoned read beat leaves a zero word in the line.
            if (state == RD)
              offchip_mem_data[{beat, 5'd0} +: 32] <= bus_ack ? bus_rdata : '0;
            if (expired) offchip_err <= 1'b1;
            timer <= '0;
            beat  <= beat_nxt;
            if (last) begin
              bus_req           <= 1'b0;
              bus_we            <= 1'b0;
              bus_addr          <= '0;
              bus_wdata         <= '0;
              offchip_mem_ready <= 1'b1;
            end else begin
              bus_addr  <= bus_addr + 32'd4;
              bus_wdata <= (state == WR) ? wline[{beat_nxt, 5'd0} +: 32] : '0;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE:    bridge_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  // A level-held enable is served once; it is re-armed only after the
  // enable is seen low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_served <= 1'b0;
      wr_served <= 1'b0;
    end else begin
      if (!offchip_mem_read_en)                rd_served <= 1'b0;
      else if (state == RD && advance && last) rd_served <= 1'b1;
      if (!offchip_mem_write_en)               wr_served <= 1'b0;
      else if (state == WR && advance && last) wr_served <= 1'b1;
    end
  end

endmodule

// File: tb/tb_offchip_line_bridge.sv
// tb_offchip_line_bridge
//   Drives line reads/writes, acts as the bus slave with per-beat wait counts,
//   and checks every beat, the ready timing, err and the delivered line
//   against a transaction-level model.
module tb_offchip_line_bridge;
  localparam int unsigned LB    = 16;
  localparam int unsigned BEATS = LB / 4;
  localparam int unsigned TO    = 8;
  localparam int          LW    = LB * 8;
  localparam int          NEVER = 99;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   offchip_mem_addr = '0;
  logic          offchip_mem_read_en = 1'b0;
  logic          offchip_mem_write_en = 1'b0;
  logic [LW-1:0] offchip_mem_wdata = '0;
  logic [LW-1:0] offchip_mem_data;
  logic          offchip_mem_ready, offchip_err, bridge_busy;
  logic          bus_req, bus_we;
  logic [31:0]   bus_addr, bus_wdata;
  logic [31:0]   bus_rdata = '0;
  logic          bus_ack = 1'b0;

  int            n_checks = 0;
  int            n_fail = 0;
  int            waits [BEATS];
  logic [LW-1:0] model_line = '0;

  offchip_line_bridge #(.LINE_BYTES(LB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .offchip_mem_addr(offchip_mem_addr),
    .offchip_mem_read_en(offchip_mem_read_en),
    .offchip_mem_write_en(offchip_mem_write_en),
    .offchip_mem_wdata(offchip_mem_wdata),
    .offchip_mem_data(offchip_mem_data),
    .offchip_mem_ready(offchip_mem_ready),
    .offchip_err(offchip_err),
    .bridge_busy(bridge_busy),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < BEATS; i++) l[32*i +: 32] = $urandom();
    return l;
  endfunction

  task automatic set_waits(input int w);
    for (int i = 0; i < BEATS; i++) waits[i] = w;
  endtask

  task automatic rand_waits(input bit allow_to);
    for (int i = 0; i < BEATS; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (allow_to && r == 0) waits[i] = NEVER;
      else if (r == 1)        waits[i] = int'(TO) - 1;
      else                    waits[i] = $urandom_range(0, 3);
    end
  endtask

  // Called at cycle 0 (the cycle whose closing edge samples the enable).
  // Returns at cycle ready+1, which may serve as cycle 0 of a chained transfer.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [LW-1:0] wl,
                      input logic [LW-1:0] rl, input bit drive, input bit scramble);
    logic [31:0]   base;
    logic [LW-1:0] exp_line;
    bit            exp_err;
    int            dur [BEATS];
    int            start [BEATS];
    int            rdy, k;
    base     = addr & ~(32'(LB) - 32'd1);
    exp_line = model_line;
    exp_err  = 1'b0;
    rdy      = 1;
    for (int i = 0; i < BEATS; i++) begin
      start[i] = rdy;
      if (waits[i] < int'(TO)) dur[i] = waits[i] + 1;
      else begin
        dur[i]  = int'(TO);
        exp_err = 1'b1;
      end
      if (!wr) exp_line[32*i +: 32] = (waits[i] < int'(TO)) ? rl[32*i +: 32] : 32'h0;
      rdy += dur[i];
    end
    if (drive) begin
      offchip_mem_addr  = addr;
      offchip_mem_wdata = wl;
      if (wr) offchip_mem_write_en = 1'b1;
      else    offchip_mem_read_en  = 1'b1;
    end
    step();
    for (int c = 1; c <= rdy; c++) begin
      k = 0;
      for (int i = 0; i < BEATS; i++) if (c >= start[i]) k = i;
      bus_ack   = 1'b0;
      bus_rdata = $urandom();
      if (c < rdy) begin
        check("bus_req", bus_req, 1);
        check("busy", bridge_busy, 1);
        check("ready_early", offchip_mem_ready, 0);
        if (c == start[k]) begin
          check("bus_addr", bus_addr, base + 32'(4 * k));
          check("bus_we", bus_we, wr);
          if (wr) check("bus_wdata", bus_wdata, wl[32*k +: 32]);
        end
        if (waits[k] < int'(TO) && c == start[k] + waits[k]) begin
          bus_ack   = 1'b1;
          bus_rdata = rl[32*k +: 32];
        end
        if (scramble && c == 2) begin
          offchip_mem_addr     = $urandom();
          offchip_mem_wdata    = rand_line();
          offchip_mem_read_en  = 1'b0;
          offchip_mem_write_en = 1'b0;
        end
      end else begin
        check("ready", offchip_mem_ready, 1);
        check("req_after", bus_req, 0);
        check("busy_ready", bridge_busy, 1);
        check("err", offchip_err, exp_err);
        check("line", offchip_mem_data, exp_line);
        bus_ack = 1'($urandom_range(0, 1));
      end
      step();
    end
    bus_ack = 1'b0;
    check("ready_once", offchip_mem_ready, 0);
    check("busy_end", bridge_busy, 0);
    check("req_end", bus_req, 0);
    model_line = exp_line;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus_ack   = 1'($urandom_range(0, 1));
      bus_rdata = $urandom();
      step();
      check("idle_req", bus_req, 0);
      check("idle_busy", bridge_busy, 0);
      check("idle_ready", offchip_mem_ready, 0);
    end
    bus_ack = 1'b0;
    check("idle_data", offchip_mem_data, model_line);
  endtask

  initial begin
    logic [LW-1:0] wl, rl;
    logic [31:0]   a;
    bit            wr;

    #2 rst = 1'b0;
    step();
    check("rst_req", bus_req, 0);
    check("rst_ready", offchip_mem_ready, 0);
    check("rst_busy", bridge_busy, 0);
    check("rst_err", offchip_err, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_data", offchip_mem_data, 0);
    rst = 1'b1;
    step();

    // Read with zero-wait acks.
    set_waits(0);
    rl = 128'h00000044_00000033_00000022_00000011;
    xfer(1'b0, 32'h0000_1234, '0, rl, 1'b1, 1'b0);
    check("t1_line", offchip_mem_data, 128'h00000044_00000033_00000022_00000011);
    offchip_mem_read_en = 1'b0;
    idle(2);

    // Write with two wait cycles per beat.
    set_waits(2);
    wl = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    xfer(1'b1, 32'h0000_4000, wl, rand_line(), 1'b1, 1'b0);
    offchip_mem_write_en = 1'b0;
    idle(3);

    // Write-back while read_en stays high: no re-issued read.
    rand_waits(1'b0);
    xfer(1'b0, $urandom(), '0, rand_line(), 1'b1, 1'b0);
    idle(4);
    rand_waits(1'b0);
    xfer(1'b1, $urandom(), rand_line(), rand_line(), 1'b1, 1'b0);
    offchip_mem_write_en = 1'b0;
    idle(4);
    offchip_mem_read_en = 1'b0;
    idle(1);
    rand_waits(1'b0);
    xfer(1'b0, $urandom(), '0, rand_line(), 1'b1, 1'b0);
    offchip_mem_read_en = 1'b0;
    idle(1);

    // Timeout on beat 2, then a clean transfer clears err.
    set_waits(1);
    waits[2] = NEVER;
    xfer(1'b0, 32'h0000_8010, '0, rand_line(), 1'b1, 1'b0);
    check("t4_word2", offchip_mem_data[95:64], 0);
    offchip_mem_read_en = 1'b0;
    idle(1);
    set_waits(0);
    xfer(1'b0, 32'h0000_8020, '0, rand_line(), 1'b1, 1'b0);
    offchip_mem_read_en = 1'b0;
    idle(1);
    // Ack on the last permitted cycle is still an ack.
    set_waits(int'(TO) - 1);
    xfer(1'b1, 32'h0000_8030, rand_line(), rand_line(), 1'b1, 1'b0);
    offchip_mem_write_en = 1'b0;
    idle(1);

    // Reset at beat 1 of a read.
    set_waits(0);
    offchip_mem_addr    = 32'h0000_2008;
    offchip_mem_read_en = 1'b1;
    step();
    bus_ack   = 1'b1;
    bus_rdata = 32'hCAFE_0001;
    step();
    bus_ack = 1'b0;
    check("t5_req_pre", bus_req, 1);
    check("t5_addr_pre", bus_addr, 32'h0000_2004);
    rst = 1'b0;
    #1;
    check("t5_req_rst", bus_req, 0);
    check("t5_busy_rst", bridge_busy, 0);
    check("t5_data_rst", offchip_mem_data, 0);
    offchip_mem_read_en = 1'b0;
    model_line = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_no_ready", offchip_mem_ready, 0);
    end
    rst = 1'b1;
    step();
    rand_waits(1'b0);
    xfer(1'b0, 32'h0000_3000, '0, rand_line(), 1'b1, 1'b0);
    offchip_mem_read_en = 1'b0;
    idle(1);

    // Both enables rise together: write, then the read.
    a  = $urandom();
    wl = rand_line();
    offchip_mem_addr     = a;
    offchip_mem_wdata    = wl;
    offchip_mem_read_en  = 1'b1;
    offchip_mem_write_en = 1'b1;
    rand_waits(1'b0);
    xfer(1'b1, a, wl, rand_line(), 1'b0, 1'b0);
    rand_waits(1'b0);
    xfer(1'b0, a, '0, rand_line(), 1'b0, 1'b0);
    idle(3);
    offchip_mem_read_en  = 1'b0;
    offchip_mem_write_en = 1'b0;
    idle(1);

    // Random transfers, with timeouts and mid-transfer input changes.
    for (int n = 0; n < 30; n++) begin
      wr = 1'($urandom_range(0, 1));
      rand_waits(1'b1);
      xfer(wr, $urandom(), rand_line(), rand_line(), 1'b1, 1'($urandom_range(0, 1)));
      offchip_mem_read_en  = 1'b0;
      offchip_mem_write_en = 1'b0;
      idle(1 + $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
